// File: rtl/debug_sequencer.sv
// Debug sequencer: takes UART command bytes to load instruction memory, run or step the
// pipeline, and stream back N_DUMP debug words as bytes, LSB first.
module debug_sequencer #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 8,
    parameter int                 NB_SEL    = 5,
    parameter int                 N_DUMP    = 32,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic               i_end,
    input  logic [NB_DATA-1:0] i_dump_word,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_instr_addr,
    output logic               o_we,
    output logic               o_pipe_rst,
    output logic               o_run,
    output logic [NB_SEL-1:0]  o_dump_sel,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    output logic               o_busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_STEP      = 3'd4;
    localparam logic [2:0] S_DUMP_SEL  = 3'd5;
    localparam logic [2:0] S_DUMP_TX   = 3'd6;
    localparam logic [2:0] S_DUMP_WAIT = 3'd7;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;
    localparam logic [NB_SEL-1:0]  SEL_LAST = NB_SEL'(N_DUMP - 1);

    logic [2:0]         state_q, state_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic               pipe_rst_q, pipe_rst_d;
    logic               ended_q, ended_d;
    logic [NB_SEL-1:0]  sel_q, sel_d;
    logic               sel_wait_q, sel_wait_d;
    logic [NB_DATA-1:0] cap_q, cap_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [1:0]         byte_next;

    function automatic logic [7:0] byte_of(input logic [NB_DATA-1:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    assign byte_next = byte_cnt_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        pipe_rst_d = pipe_rst_q;
        ended_d    = ended_q;
        sel_d      = sel_q;
        sel_wait_d = sel_wait_q;
        cap_d      = cap_q;
        tx_data_d  = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            addr_d     = '0;
                            byte_cnt_d = '0;
                            pipe_rst_d = 1'b1;
                            ended_d    = 1'b0;
                            state_d    = S_LOAD;
                        end
                        CMD_CONT: begin
                            pipe_rst_d = 1'b0;
                            if (ended_q) begin
                                sel_d      = '0;
                                sel_wait_d = 1'b1;
                                byte_cnt_d = '0;
                                state_d    = S_DUMP_SEL;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        CMD_STEP: begin
                            pipe_rst_d = 1'b0;
                            state_d    = S_STEP;
                        end
                        CMD_DUMP: begin
                            sel_d      = '0;
                            sel_wait_d = 1'b1;
                            byte_cnt_d = '0;
                            state_d    = S_DUMP_SEL;
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (i_rx_done) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byte_cnt_q == 2'(b)) word_d[8*b +: 8] = i_rx_data;
                    end
                    byte_cnt_d = byte_next;
                    if (byte_cnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                byte_cnt_d = '0;
                // Stop at the halt word or the top of memory; the address never wraps.
                if (word_q == HALT_WORD || addr_q == ADDR_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (i_end) begin
                    ended_d    = 1'b1;
                    sel_d      = '0;
                    sel_wait_d = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = S_DUMP_SEL;
                end
            end
            S_STEP: begin
                if (i_end) ended_d = 1'b1;
                sel_d      = '0;
                sel_wait_d = 1'b1;
                byte_cnt_d = '0;
                state_d    = S_DUMP_SEL;
            end
            S_DUMP_SEL: begin
                // Debug read data lags the select by a cycle, so capture on the second cycle.
                if (sel_wait_q) begin
                    sel_wait_d = 1'b0;
                end else begin
                    cap_d     = i_dump_word;
                    tx_data_d = byte_of(i_dump_word, 2'd0);
                    state_d   = S_DUMP_TX;
                end
            end
            S_DUMP_TX: begin
                state_d = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (i_tx_done) begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        if (sel_q == SEL_LAST) begin
                            state_d = S_IDLE;
                        end else begin
                            sel_d      = sel_q + 1'b1;
                            sel_wait_d = 1'b1;
                            state_d    = S_DUMP_SEL;
                        end
                    end else begin
                        byte_cnt_d = byte_next;
                        tx_data_d  = byte_of(cap_q, byte_next);
                        state_d    = S_DUMP_TX;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            pipe_rst_q <= 1'b1;
            ended_q    <= 1'b0;
            sel_q      <= '0;
            sel_wait_q <= 1'b0;
            cap_q      <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            pipe_rst_q <= pipe_rst_d;
            ended_q    <= ended_d;
            sel_q      <= sel_d;
            sel_wait_q <= sel_wait_d;
            cap_q      <= cap_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign o_instruction = word_q;
    assign o_instr_addr  = addr_q;
    assign o_we          = (state_q == S_WRITE);
    assign o_pipe_rst    = pipe_rst_q;
    // A step after the program has ended only dumps; the pipeline is not advanced.
    assign o_run         = (state_q == S_RUN) || (state_q == S_STEP && !ended_q);
    assign o_dump_sel    = sel_q;
    assign o_tx_start    = (state_q == S_DUMP_TX);
    assign o_tx_data     = tx_data_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: command vector table, hand-written load/run/step/reset
// sequences, and randomized command/dump runs checked against a small behavioural model.
module tb_debug_sequencer;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 8;
    localparam int NB_SEL  = 5;
    localparam int N_DUMP  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic        end_i = 1'b0;
    logic [31:0] dump_word = 32'h0;

    logic [31:0] o_instruction;
    logic [7:0]  o_instr_addr;
    logic        o_we, o_pipe_rst, o_run, o_tx_start, o_busy;
    logic [4:0]  o_dump_sel;
    logic [7:0]  o_tx_data;

    logic [7:0]  rx2_data = 8'h00;
    logic        rx2_done = 1'b0;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'h0;
    logic [31:0] d2_instruction;
    logic [1:0]  d2_instr_addr;
    logic        d2_we, d2_pipe_rst, d2_run, d2_tx_start, d2_busy;
    logic [4:0]  d2_dump_sel;
    logic [7:0]  d2_tx_data;

    debug_sequencer #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_SEL(NB_SEL), .N_DUMP(N_DUMP)) dut (
        .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .i_end(end_i), .i_dump_word(dump_word),
        .o_instruction(o_instruction), .o_instr_addr(o_instr_addr), .o_we(o_we),
        .o_pipe_rst(o_pipe_rst), .o_run(o_run), .o_dump_sel(o_dump_sel),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy)
    );

    debug_sequencer #(.NB_DATA(NB_DATA), .NB_ADDR(2), .NB_SEL(NB_SEL), .N_DUMP(N_DUMP)) dut2 (
        .clk(clk), .i_rst(rst), .i_rx_data(rx2_data), .i_rx_done(rx2_done),
        .i_tx_done(zero_bit), .i_end(zero_bit), .i_dump_word(zero_word),
        .o_instruction(d2_instruction), .o_instr_addr(d2_instr_addr), .o_we(d2_we),
        .o_pipe_rst(d2_pipe_rst), .o_run(d2_run), .o_dump_sel(d2_dump_sel),
        .o_tx_start(d2_tx_start), .o_tx_data(d2_tx_data), .o_busy(d2_busy)
    );

    // Debug read port model: one-cycle registered read of the bench's word array.
    logic [31:0] dmem [N_DUMP];
    always @(posedge clk) dump_word <= dmem[o_dump_sel];

    logic [39:0] we_log[$];
    logic [33:0] we2_log[$];
    logic [7:0]  tx_log[$];
    int          run_cycles = 0;

    always @(negedge clk) begin
        if (o_we) we_log.push_back({o_instr_addr, o_instruction});
        if (d2_we) we2_log.push_back({d2_instr_addr, d2_instruction});
        if (o_tx_start) tx_log.push_back(o_tx_data);
        if (o_run) run_cycles++;
    end

    // UART transmitter model: answers each start with tx_done after a random delay.
    bit tx_auto = 1'b0;
    initial begin
        forever begin
            int n;
            @(negedge clk);
            if (o_tx_start && tx_auto) begin
                n = $urandom_range(1, 4);
                repeat (n) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_cmd(b);
        repeat (2) @(posedge clk);
    endtask

    task automatic send2_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx2_data = b;
        rx2_done = 1'b1;
        @(posedge clk);
        #1 rx2_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (o_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, o_busy}, 64'd0);
    endtask

    // Expected dump: every word of the debug array, each sent as 4 bytes LSB first.
    task automatic check_dump(input string name, input int base);
        int got, bad, idx;
        logic [7:0] e;
        got = tx_log.size() - base;
        check({name, " count"}, 64'(got), 64'(4 * N_DUMP));
        bad = 0;
        for (int w = 0; w < N_DUMP; w++) begin
            for (int b = 0; b < 4; b++) begin
                e = dmem[w][8*b +: 8];
                idx = base + 4 * w + b;
                if (idx < tx_log.size()) begin
                    if (tx_log[idx] !== e) bad++;
                end else begin
                    bad++;
                end
            end
        end
        check({name, " bytes"}, 64'(bad), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " ctrl"}, {59'd0, o_pipe_rst, o_we, o_run, o_tx_start, o_busy}, 64'b10000);
        check({name, " data"}, {o_instruction, o_instr_addr, o_dump_sel, o_tx_data}, 64'd0);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [2:0] exp;   // {busy, run, pipe_rst} in the cycle after the command
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        int          rb, tb, wb, n, k, r, cnt_rst;
        bit          ended_m, coin;
        logic [7:0]  bt;
        logic [31:0] w5[5];

        vecs[0] = '{8'h4C, 3'b101};
        vecs[1] = '{8'h43, 3'b110};
        vecs[2] = '{8'h53, 3'b110};
        vecs[3] = '{8'h44, 3'b101};
        vecs[4] = '{8'h00, 3'b001};
        vecs[5] = '{8'h41, 3'b001};
        vecs[6] = '{8'h6C, 3'b001};
        vecs[7] = '{8'hFF, 3'b001};

        for (int i = 0; i < N_DUMP; i++) dmem[i] = $urandom;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset dut2", {d2_pipe_rst, d2_we, d2_busy, d2_instr_addr}, {1'b1, 1'b0, 1'b0, 2'd0});
        @(posedge clk);
        #1 rst = 1'b0;

        // Command decode from a fresh reset
        for (int i = 0; i < 8; i++) begin
            send_cmd(vecs[i].cmd);
            @(negedge clk);
            check($sformatf("cmd %02h", vecs[i].cmd), {61'd0, o_busy, o_run, o_pipe_rst}, {61'd0, vecs[i].exp});
            do_reset();
        end

        // Load: two words, second one is the halt word
        wb = we_log.size();
        send_byte(8'h4C);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        wait_idle("load idle", 50);
        check("load write count", 64'(we_log.size() - wb), 64'd2);
        if (we_log.size() >= wb + 2) begin
            check("load write 0", {24'd0, we_log[wb]}, {24'd0, 8'd0, 32'h12345678});
            check("load write 1", {24'd0, we_log[wb+1]}, {24'd0, 8'd1, 32'hFFFFFFFF});
        end
        check("load pipe_rst held", {63'd0, o_pipe_rst}, 64'd1);

        // Step with a known word 0
        dmem[0] = 32'hAABBCCDD;
        tx_auto = 1'b1;
        rb = run_cycles; tb = tx_log.size();
        send_cmd(8'h53);
        wait_idle("step idle", 4000);
        check("step run cycles", 64'(run_cycles - rb), 64'd1);
        if (tx_log.size() >= tb + 4)
            check("step first word", {32'd0, tx_log[tb+3], tx_log[tb+2], tx_log[tb+1], tx_log[tb]}, 64'hAABBCCDD);
        check_dump("step dump", tb);

        // Continue, end arrives in the 10th run cycle
        for (int i = 0; i < N_DUMP; i++) dmem[i] = $urandom;
        rb = run_cycles; tb = tx_log.size();
        send_cmd(8'h43);
        repeat (9) @(posedge clk);
        #1 end_i = 1'b1;
        @(posedge clk);
        #1 end_i = 1'b0;
        wait_idle("run idle", 4000);
        check("run cycles", 64'(run_cycles - rb), 64'd10);
        check_dump("run dump", tb);

        // Step after end: dump only, bytes received meanwhile are dropped
        rb = run_cycles; tb = tx_log.size(); wb = we_log.size();
        send_cmd(8'h53);
        fork
            wait_idle("ended step idle", 4000);
            begin
                for (int i = 0; i < 16; i++) begin
                    r = $urandom_range(0, 4);
                    case (r)
                        0: bt = 8'h4C;
                        1: bt = 8'h43;
                        2: bt = 8'h53;
                        3: bt = 8'h44;
                        default: bt = 8'($urandom);
                    endcase
                    send_byte(bt);
                    repeat (3) @(posedge clk);
                end
            end
        join
        check("ended step run cycles", 64'(run_cycles - rb), 64'd0);
        check("ended step no writes", 64'(we_log.size() - wb), 64'd0);
        check("ended step pipe_rst", {63'd0, o_pipe_rst}, 64'd0);
        check_dump("ended step dump", tb);

        // Randomized commands against the ended-flag model
        send_byte(8'h4C);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        wait_idle("reload idle", 50);
        ended_m = 1'b0;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N_DUMP; i++) dmem[i] = $urandom;
            r = $urandom_range(0, 2);
            coin = 1'($urandom);
            rb = run_cycles; tb = tx_log.size();
            k = 0;
            if (r == 0) begin
                send_cmd(8'h44);
            end else if (r == 1) begin
                k = ended_m ? 0 : 1;
                end_i = coin;
                send_cmd(8'h53);
                @(posedge clk);
                #1 end_i = 1'b0;
                if (coin) ended_m = 1'b1;
            end else begin
                send_cmd(8'h43);
                if (!ended_m) begin
                    k = $urandom_range(1, 20);
                    repeat (k - 1) @(posedge clk);
                    #1 end_i = 1'b1;
                    @(posedge clk);
                    #1 end_i = 1'b0;
                    ended_m = 1'b1;
                end
            end
            wait_idle($sformatf("random %0d idle", it), 4000);
            check($sformatf("random %0d run cycles", it), 64'(run_cycles - rb), 64'(k));
            check_dump($sformatf("random %0d dump", it), tb);
        end

        // Narrow address space: five words, only addresses 0..3 written
        for (int i = 0; i < 4; i++) begin
            w5[i] = $urandom;
            if (w5[i] == 32'hFFFFFFFF) w5[i] = 32'h0;
        end
        wb = we2_log.size();
        send2_byte(8'h4C);
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++) send2_byte(w5[i][8*b +: 8]);
        for (int b = 0; b < 4; b++) begin
            bt = 8'($urandom);
            if (bt == 8'h4C || bt == 8'h43 || bt == 8'h53 || bt == 8'h44) bt = bt ^ 8'h80;
            send2_byte(bt);
        end
        @(negedge clk);
        check("narrow write count", 64'(we2_log.size() - wb), 64'd4);
        for (int i = 0; i < 4; i++)
            if (we2_log.size() > wb + i)
                check($sformatf("narrow write %0d", i), {30'd0, we2_log[wb+i]}, {30'd0, 2'(i), w5[i]});
        check("narrow idle and addr", {61'd0, d2_busy, d2_instr_addr}, 64'd3);

        // Reset in the middle of a dump
        for (int i = 0; i < N_DUMP; i++) dmem[i] = $urandom;
        tb = tx_log.size();
        send_cmd(8'h44);
        n = 0;
        while (tx_log.size() - tb < 6 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("mid-dump bytes before reset", 64'(tx_log.size() - tb), 64'd6);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid-dump reset");
        cnt_rst = tx_log.size();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        check("no tx after reset", 64'(tx_log.size() - cnt_rst), 64'd0);
        tb = tx_log.size();
        send_cmd(8'h44);
        wait_idle("redump idle", 4000);
        if (tx_log.size() >= tb + 4)
            check("redump starts at sel 0", {32'd0, tx_log[tb+3], tx_log[tb+2], tx_log[tb+1], tx_log[tb]}, {32'd0, dmem[0]});
        check_dump("redump", tb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
